// File: rtl/centroid_pkg.sv
// Shared types for the centroid frame sequencer: FSM state encoding and the
// result record handed downstream.
package centroid_pkg;

    localparam int unsigned CEN_DW = 8;
    localparam int unsigned CEN_CW = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ARM,
        ST_SCAN,
        ST_WAIT_DONE,
        ST_OUT
    } state_e;

    // Field widths follow CEN_DW/CEN_CW; the top defaults its parameters to these.
    typedef struct packed {
        logic [CEN_DW-1:0] x;
        logic [CEN_DW-1:0] y;
        logic [CEN_CW-1:0] count;
        logic              empty;
        logic              timeout;
    } result_t;

endpackage

// File: rtl/centroid_coord_gen.sv
// Raster coordinate generator: x advances per accepted pixel, end-of-line wraps
// x and advances y; both counters saturate instead of wrapping.
module centroid_coord_gen
    import centroid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CEN_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  logic                  eol_i,
    input  logic                  eof_i,
    output logic [DATA_WIDTH-1:0] x_o,
    output logic [DATA_WIDTH-1:0] y_o
);

    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i && !eof_i) begin
            // End of frame wins over end of line; coordinates are re-armed anyway.
            if (eol_i) begin
                x_d = '0;
                if (y_q != '1) y_d = y_q + DATA_WIDTH'(1);
            end else if (x_q != '1) begin
                x_d = x_q + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/centroid_frame_ctrl.sv
// Frame sequencer for the centroid engine: forwards foreground pixel
// coordinates, closes the frame, waits for the engine and returns its result.
module centroid_frame_ctrl
    import centroid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = CEN_DW,
    parameter int unsigned COUNT_WIDTH    = CEN_CW,
    parameter int unsigned MIN_COUNT      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic                   pix_mask,
    input  logic                   pix_eol,
    input  logic                   pix_eof,
    output logic                   frame_busy,
    output logic                   pix_drop,
    output logic [DATA_WIDTH-1:0]  cen_x,
    output logic [DATA_WIDTH-1:0]  cen_y,
    output logic                   cen_enable,
    output logic                   cen_end,
    input  logic [DATA_WIDTH-1:0]  cen_res_x,
    input  logic [DATA_WIDTH-1:0]  cen_res_y,
    input  logic                   cen_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_WIDTH-1:0]  res_x,
    output logic [DATA_WIDTH-1:0]  res_y,
    output logic [COUNT_WIDTH-1:0] res_count,
    output logic                   res_empty,
    output logic                   res_timeout
);

    localparam int unsigned            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]          TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MIN  = COUNT_WIDTH'(MIN_COUNT);

    state_e                 state_q, state_d;
    logic                   init_phase_q, init_phase_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [DATA_WIDTH-1:0]  cen_x_q, cen_x_d;
    logic [DATA_WIDTH-1:0]  cen_y_q, cen_y_d;
    logic                   cen_enable_q, cen_enable_d;
    logic                   cen_end_q, cen_end_d;
    logic                   pix_drop_q, pix_drop_d;
    logic                   frame_busy_q, frame_busy_d;
    logic                   res_valid_q, res_valid_d;
    result_t                res_q, res_d;

    logic [DATA_WIDTH-1:0]  x_cur, y_cur;
    logic                   coord_clear, coord_step, frame_empty;

    assign coord_clear = (state_q == ST_ARM);
    assign coord_step  = (state_q == ST_SCAN) && pix_valid;
    assign frame_empty = (count_q < COUNT_MIN);

    centroid_coord_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (coord_clear),
        .step_i  (coord_step),
        .eol_i   (pix_eol),
        .eof_i   (pix_eof),
        .x_o     (x_cur),
        .y_o     (y_cur)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        init_phase_d = init_phase_q;
        count_d      = count_q;
        timer_d      = timer_q;
        cen_x_d      = cen_x_q;
        cen_y_d      = cen_y_q;
        cen_enable_d = 1'b0;
        cen_end_d    = 1'b0;
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        pix_drop_d   = pix_valid && (state_q != ST_SCAN);

        case (state_q)
            ST_INIT: begin
                // A lone data_end parks an engine that a reset caught mid-frame.
                cen_x_d = '0;
                cen_y_d = '0;
                if (!init_phase_q) begin
                    cen_end_d    = 1'b1;
                    init_phase_d = 1'b1;
                end else begin
                    init_phase_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (frame_start) state_d = ST_ARM;
            end
            ST_ARM: begin
                cen_enable_d = 1'b1;
                cen_x_d      = '0;
                cen_y_d      = '0;
                count_d      = '0;
                state_d      = ST_SCAN;
            end
            ST_SCAN: begin
                if (pix_valid) begin
                    cen_enable_d = pix_mask;
                    cen_end_d    = pix_eof;
                    cen_x_d      = x_cur;
                    cen_y_d      = y_cur;
                    if (pix_mask && (count_q != '1)) count_d = count_q + COUNT_WIDTH'(1);
                    if (pix_eof) begin
                        timer_d = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                timer_d = timer_q + TW'(1);
                // timer_q == 0 masks a done level left over from the previous frame.
                if (cen_done && (timer_q != '0)) begin
                    res_d.x       = frame_empty ? '0 : cen_res_x;
                    res_d.y       = frame_empty ? '0 : cen_res_y;
                    res_d.count   = count_q;
                    res_d.empty   = frame_empty;
                    res_d.timeout = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = ST_OUT;
                end else if (timer_q == TIMER_LAST) begin
                    res_d.x       = '0;
                    res_d.y       = '0;
                    res_d.count   = count_q;
                    res_d.empty   = frame_empty;
                    res_d.timeout = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        frame_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_phase_q <= 1'b0;
            count_q      <= '0;
            timer_q      <= '0;
            cen_x_q      <= '0;
            cen_y_q      <= '0;
            cen_enable_q <= 1'b0;
            cen_end_q    <= 1'b0;
            pix_drop_q   <= 1'b0;
            frame_busy_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
        end else begin
            init_phase_q <= init_phase_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            cen_x_q      <= cen_x_d;
            cen_y_q      <= cen_y_d;
            cen_enable_q <= cen_enable_d;
            cen_end_q    <= cen_end_d;
            pix_drop_q   <= pix_drop_d;
            frame_busy_q <= frame_busy_d;
            res_valid_q  <= res_valid_d;
            res_q        <= res_d;
        end
    end

    assign frame_busy  = frame_busy_q;
    assign pix_drop    = pix_drop_q;
    assign cen_x       = cen_x_q;
    assign cen_y       = cen_y_q;
    assign cen_enable  = cen_enable_q;
    assign cen_end     = cen_end_q;
    assign res_valid   = res_valid_q;
    assign res_x       = res_q.x;
    assign res_y       = res_q.y;
    assign res_count   = res_q.count;
    assign res_empty   = res_q.empty;
    assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_centroid_frame_ctrl.sv
// Bench for centroid_frame_ctrl: behavioural centroid engine, raster frame
// driver and a frame-level reference for the engine beats and the result.
module tb_centroid_frame_ctrl;

    localparam int DW = 8;
    localparam int CW = 32;
    localparam int BW = 2 + 2 * DW;

    logic          clk;
    logic          rst_n;
    logic          frame_start, pix_valid, pix_mask, pix_eol, pix_eof;
    logic          frame_busy, pix_drop;
    logic [DW-1:0] cen_x, cen_y;
    logic          cen_enable, cen_end;
    logic [DW-1:0] cen_res_x, cen_res_y;
    logic          cen_done;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_x, res_y;
    logic [CW-1:0] res_count;
    logic          res_empty, res_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit            frame_mask [0:4095];
    logic [BW-1:0] cap_q[$];
    bit            capture_on = 0;
    int            end_cyc = 0;

    int eng_n, eng_sx, eng_sy;
    int eng_cd      = -1;
    int eng_latency = 3;
    bit eng_started = 0;
    bit eng_respond = 1;

    centroid_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_mask    (pix_mask),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .frame_busy  (frame_busy),
        .pix_drop    (pix_drop),
        .cen_x       (cen_x),
        .cen_y       (cen_y),
        .cen_enable  (cen_enable),
        .cen_end     (cen_end),
        .cen_res_x   (cen_res_x),
        .cen_res_y   (cen_res_y),
        .cen_done    (cen_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_x       (res_x),
        .res_y       (res_y),
        .res_count   (res_count),
        .res_empty   (res_empty),
        .res_timeout (res_timeout)
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- behavioural engine + beat monitor ----------------
    // First enable after data_end is the start token; done rises a few cycles
    // after data_end and stays up until the next start token.
    initial begin
        cen_done  = 0;
        cen_res_x = '0;
        cen_res_y = '0;
        forever begin
            @(negedge clk);
            if (capture_on && (cen_enable || cen_end))
                cap_q.push_back({cen_enable, cen_end, cen_x, cen_y});
            if (cen_end) end_cyc = cyc;
            if (cen_enable && !eng_started) begin
                eng_started = 1;
                eng_n = 0; eng_sx = 0; eng_sy = 0;
                cen_done = 0;
                eng_cd = -1;
            end else if (cen_enable) begin
                eng_n++;
                eng_sx += int'(cen_x);
                eng_sy += int'(cen_y);
            end
            if (cen_end) begin
                eng_started = 0;
                eng_cd = eng_latency;
            end
            if (eng_cd == 0) begin
                if (eng_respond) begin
                    cen_done  = 1;
                    cen_res_x = (eng_n > 0) ? DW'(eng_sx / eng_n) : 8'hA5;
                    cen_res_y = (eng_n > 0) ? DW'(eng_sy / eng_n) : 8'h5A;
                end
                eng_cd = -1;
            end else if (eng_cd > 0) begin
                eng_cd--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [BW-1:0] beat(input logic en, input logic e, input int x, input int y);
        return {en, e, DW'(x), DW'(y)};
    endfunction

    task automatic drive_idle();
        frame_start = 0;
        pix_valid   = 0;
        pix_mask    = 0;
        pix_eol     = 0;
        pix_eof     = 0;
    endtask

    task automatic fill_mask(input int w, input int h, input int pct);
        for (int i = 0; i < w * h; i++) frame_mask[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic apply_reset(input string name);
        int ends, ens, first_end;
        @(negedge clk);
        rst_n = 0;
        drive_idle();
        #1;
        n_checks++;
        if ({frame_busy, pix_drop, cen_enable, cen_end, cen_x, cen_y, res_valid,
             res_x, res_y, res_count, res_empty, res_timeout} !== '0) begin
            n_fail++;
            $display("FAIL %s reset_outputs: got busy=%b drop=%b en=%b end=%b x=%h y=%h rv=%b rx=%h ry=%h cnt=%h e=%b t=%b, required all 0",
                     name, frame_busy, pix_drop, cen_enable, cen_end, cen_x, cen_y, res_valid,
                     res_x, res_y, res_count, res_empty, res_timeout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        ends = 0; ens = 0; first_end = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cen_end === 1'b1) begin
                ends++;
                if (first_end < 0) first_end = i;
            end
            if (cen_enable !== 1'b0) ens++;
        end
        n_checks++;
        if (ends != 1 || first_end > 1) begin
            n_fail++;
            $display("FAIL %s init_flush: got %0d cen_end pulses (first at %0d), required 1 within 2 cycles", name, ends, first_end);
        end
        n_checks++;
        if (ens != 0) begin
            n_fail++;
            $display("FAIL %s init_enable: got %0d cen_enable cycles, required 0", name, ens);
        end
        n_checks++;
        if (frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s init_busy: got frame_busy=%b, required 0", name, frame_busy);
        end
    endtask

    // Drives a whole frame from frame_mask, checks the engine beats and the result.
    task automatic run_frame(input string name, input int w, input int h,
                             input bit exp_timeout, input int ready_delay);
        logic [BW-1:0] exp_q[$];
        int n, sx, sy, ex, ey, waited;
        bit got, prev_v;
        logic [DW-1:0] exp_x, exp_y, snap_x, snap_y;
        logic [CW-1:0] snap_cnt;
        logic          exp_empty, snap_e, snap_t;

        n = 0; sx = 0; sy = 0;
        exp_q.push_back(beat(1'b1, 1'b0, 0, 0));
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                bit m, last;
                m    = frame_mask[yy * w + xx];
                last = (yy == h - 1) && (xx == w - 1);
                ex   = (xx > 255) ? 255 : xx;
                ey   = (yy > 255) ? 255 : yy;
                if (m || last) exp_q.push_back(beat(m, last, ex, ey));
                if (m) begin
                    n++; sx += ex; sy += ey;
                end
            end
        end
        exp_empty = (n < 1);
        exp_x = (exp_timeout || exp_empty) ? '0 : DW'(sx / n);
        exp_y = (exp_timeout || exp_empty) ? '0 : DW'(sy / n);

        cap_q.delete();
        capture_on = 1;
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    pix_valid = 0;
                    pix_mask  = 1'($urandom);
                    pix_eol   = 1'($urandom);
                    pix_eof   = 1'($urandom);
                end
                @(negedge clk);
                pix_valid = 1;
                pix_mask  = frame_mask[yy * w + xx];
                pix_eol   = (xx == w - 1);
                pix_eof   = (yy == h - 1) && (xx == w - 1);
            end
        end
        @(negedge clk);
        drive_idle();

        got = 0;
        for (waited = 0; waited < 200; waited++) begin
            if (res_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s res_valid_wait: got res_valid=%b after 200 cycles, required 1", name, res_valid);
            capture_on = 0;
            return;
        end

        n_checks++;
        if (res_x !== exp_x || res_y !== exp_y) begin
            n_fail++;
            $display("FAIL %s res_xy: got (%0d,%0d), required (%0d,%0d)", name, res_x, res_y, exp_x, exp_y);
        end
        n_checks++;
        if (res_count !== CW'(n)) begin
            n_fail++;
            $display("FAIL %s res_count: got %0d, required %0d", name, res_count, n);
        end
        n_checks++;
        if (res_empty !== exp_empty || res_timeout !== exp_timeout) begin
            n_fail++;
            $display("FAIL %s res_flags: got empty=%b timeout=%b, required empty=%b timeout=%b",
                     name, res_empty, res_timeout, exp_empty, exp_timeout);
        end
        if (exp_timeout) begin
            n_checks++;
            if (cyc - end_cyc != 64) begin
                n_fail++;
                $display("FAIL %s timeout_latency: got %0d cycles, required 64", name, cyc - end_cyc);
            end
        end

        snap_x = res_x; snap_y = res_y; snap_cnt = res_count; snap_e = res_empty; snap_t = res_timeout;
        for (int d = 0; d < ready_delay; d++) begin
            frame_start = ($urandom_range(0, 3) == 0);
            pix_valid   = 1'($urandom);
            pix_mask    = 1;
            pix_eol     = 1'($urandom);
            pix_eof     = 1'($urandom);
            prev_v      = pix_valid;
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_x !== snap_x || res_y !== snap_y || res_count !== snap_cnt ||
                res_empty !== snap_e || res_timeout !== snap_t) begin
                n_fail++;
                $display("FAIL %s res_hold[%0d]: got rv=%b x=%0d y=%0d cnt=%0d, required rv=1 x=%0d y=%0d cnt=%0d",
                         name, d, res_valid, res_x, res_y, res_count, snap_x, snap_y, snap_cnt);
            end
            n_checks++;
            if (pix_drop !== prev_v || cen_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold_drop[%0d]: got pix_drop=%b cen_enable=%b, required pix_drop=%b cen_enable=0",
                         name, d, pix_drop, cen_enable, prev_v);
            end
        end

        drive_idle();
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        n_checks++;
        if (res_valid !== 1'b0 || frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: got res_valid=%b frame_busy=%b, required 0 0", name, res_valid, frame_busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_accept: got frame_busy=%b, required 0", name, frame_busy);
        end
        capture_on = 0;

        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d engine beats, required %0d", name, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s beat[%0d]: got en=%b end=%b (%0d,%0d), required en=%b end=%b (%0d,%0d)",
                         name, i, cap_q[i][BW-1], cap_q[i][BW-2], cap_q[i][2*DW-1:DW], cap_q[i][DW-1:0],
                         exp_q[i][BW-1], exp_q[i][BW-2], exp_q[i][2*DW-1:DW], exp_q[i][DW-1:0]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_basic_frame();
        fill_mask(4, 4, 0);
        frame_mask[1 * 4 + 1] = 1;
        frame_mask[1 * 4 + 2] = 1;
        frame_mask[2 * 4 + 1] = 1;
        frame_mask[2 * 4 + 2] = 1;
        run_frame("basic_4x4", 4, 4, 0, 0);
    endtask

    task automatic test_empty_frame();
        fill_mask(4, 4, 0);
        run_frame("empty_4x4", 4, 4, 0, 1);
    endtask

    task automatic test_timeout();
        eng_respond = 0;
        fill_mask(5, 3, 50);
        run_frame("timeout", 5, 3, 1, 0);
        eng_respond = 1;
    endtask

    task automatic test_backpressure();
        fill_mask(6, 3, 40);
        run_frame("backpressure", 6, 3, 0, 10);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(1, 9);
            h = $urandom_range(1, 6);
            fill_mask(w, h, $urandom_range(0, 100));
            run_frame($sformatf("random%0d", f), w, h, 0, $urandom_range(0, 3));
        end
    endtask

    task automatic test_saturation();
        fill_mask(260, 1, 0);
        for (int i = 250; i < 260; i++) frame_mask[i] = 1'($urandom);
        frame_mask[259] = 1;
        run_frame("sat_x", 260, 1, 0, 0);
        fill_mask(1, 260, 0);
        for (int i = 250; i < 260; i++) frame_mask[i] = 1'($urandom);
        frame_mask[257] = 1;
        run_frame("sat_y", 1, 260, 0, 0);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1;
            pix_mask  = 1;
            pix_eol   = 0;
            pix_eof   = 0;
        end
        apply_reset("mid_scan");
        fill_mask(5, 4, 50);
        run_frame("after_reset", 5, 4, 0, 1);
    endtask

    initial begin
        rst_n     = 1;
        res_ready = 0;
        drive_idle();
        test_reset();
        test_basic_frame();
        test_empty_frame();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
